// File: rtl/gp0_cmd_pkg.sv
// rtl/gp0_cmd_pkg.sv - GP0 sequencer states, opcode ranges and command length helper
package gp0_cmd_pkg;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_PARAM,
    ST_POLYLINE,
    ST_XFER_IN,
    ST_XFER_OUT
  } seqState_t;

  localparam logic [7:0] OP_FILL    = 8'h02;
  localparam logic [7:0] OP_POLY_LO = 8'h20;
  localparam logic [7:0] OP_POLY_HI = 8'h3F;
  localparam logic [7:0] OP_LINE_LO = 8'h40;
  localparam logic [7:0] OP_LINE_HI = 8'h5F;
  localparam logic [7:0] OP_RECT_LO = 8'h60;
  localparam logic [7:0] OP_RECT_HI = 8'h7F;
  localparam logic [7:0] OP_COPY_LO = 8'h80;
  localparam logic [7:0] OP_COPY_HI = 8'h9F;
  localparam logic [7:0] OP_XIN_LO  = 8'hA0;
  localparam logic [7:0] OP_XIN_HI  = 8'hBF;
  localparam logic [7:0] OP_XOUT_LO = 8'hC0;
  localparam logic [7:0] OP_XOUT_HI = 8'hDF;
  localparam logic [7:0] OP_ENV_LO  = 8'hE1;
  localparam logic [7:0] OP_ENV_HI  = 8'hE6;

  localparam logic [31:0] POLYLINE_TERM_MASK  = 32'hF000F000;
  localparam logic [31:0] POLYLINE_TERM_VALUE = 32'h50005000;

  // Fixed word count including the header; 0 for polylines and non-forwarded opcodes.
  function automatic logic [3:0] gp0_cmd_len(input logic [7:0] op);
    logic [3:0] n;
    n = op[3] ? 4'd4 : 4'd3;
    if (op == OP_FILL) return 4'd3;
    if (op >= OP_POLY_LO && op <= OP_POLY_HI)
      return 4'd1 + n + (op[2] ? n : 4'd0) + (op[4] ? n - 4'd1 : 4'd0);
    if (op >= OP_LINE_LO && op <= OP_LINE_HI)
      return op[3] ? 4'd0 : 4'd3 + {3'd0, op[4]};
    if (op >= OP_RECT_LO && op <= OP_RECT_HI)
      return 4'd2 + {3'd0, op[2]} + {3'd0, op[4:3] == 2'b00};
    if (op >= OP_COPY_LO && op <= OP_COPY_HI) return 4'd4;
    if (op >= OP_XIN_LO && op <= OP_XOUT_HI) return 4'd3;
    return 4'd0;
  endfunction

endpackage

// File: rtl/gp0_command_sequencer_if.sv
// rtl/gp0_command_sequencer_if.sv - Downstream GP0 command word stream with first/last framing
interface gp0_command_sequencer_if;
  logic        cmdValid;
  logic        cmdReady;
  logic [31:0] cmdData;
  logic        cmdFirst;
  logic        cmdLast;

  modport master (output cmdValid, cmdData, cmdFirst, cmdLast, input cmdReady);
  modport slave  (input cmdValid, cmdData, cmdFirst, cmdLast, output cmdReady);
endinterface

// File: rtl/gp0_out_slot.sv
// rtl/gp0_out_slot.sv - One-entry valid/ready output register for the command stream
module gp0_out_slot (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        load,
  input  logic [31:0] data,
  input  logic        first,
  input  logic        last,
  output logic        free,
  gp0_command_sequencer_if.master cmd
);

  assign free = !cmd.cmdValid || cmd.cmdReady;

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      cmd.cmdValid <= 1'b0;
      cmd.cmdData  <= 32'd0;
      cmd.cmdFirst <= 1'b0;
      cmd.cmdLast  <= 1'b0;
    end else if (load) begin
      cmd.cmdValid <= 1'b1;
      cmd.cmdData  <= data;
      cmd.cmdFirst <= first;
      cmd.cmdLast  <= last;
    end else if (cmd.cmdReady) begin
      cmd.cmdValid <= 1'b0;
    end
  end

endmodule

// File: rtl/gp0_command_sequencer.sv
// rtl/gp0_command_sequencer.sv - GP0 header decode into environment strobes and a framed command stream
// Optional macro GP0_TEXPAGE_FROM_POLY_EN enables the texpage strobe on textured polygon UV1 words.
module gp0_command_sequencer
  import gp0_cmd_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_fifoEmpty,
  input  logic [31:0] i_fifoData,
  output logic        o_fifoRead,
  input  logic        i_primBusy,
  input  logic        i_xferDone,
  output logic        o_loadE5Offsets,
  output logic        o_loadTexPageE1,
  output logic        o_loadTexPage,
  output logic        o_loadTexWindowSetting,
  output logic        o_loadDrawAreaTL,
  output logic        o_loadDrawAreaBR,
  output logic        o_loadMaskSetting,
  output logic [31:0] o_fifoDataOut,
  gp0_command_sequencer_if.master cmd
);

  seqState_t  state, afterState, hdrAfter;
  logic [3:0] rem, hdrLen;
  logic [1:0] polyCnt;
  logic       polyGouraud;
  logic [7:0] op;
  logic       isEnv, isPoly, isPolyline, isTerm, slotFree;
  logic       popOk, fwd, fwdFirst, fwdLast;

  assign op         = i_fifoData[31:24];
  assign hdrLen     = gp0_cmd_len(op);
  assign isEnv      = op >= OP_ENV_LO && op <= OP_ENV_HI;
  assign isPoly     = op >= OP_POLY_LO && op <= OP_POLY_HI;
  assign isPolyline = op >= OP_LINE_LO && op <= OP_LINE_HI && op[3];
  assign isTerm     = (i_fifoData & POLYLINE_TERM_MASK) == POLYLINE_TERM_VALUE;
  assign hdrAfter   = (op >= OP_XIN_LO && op <= OP_XIN_HI)   ? ST_XFER_IN  :
                      (op >= OP_XOUT_LO && op <= OP_XOUT_HI) ? ST_XFER_OUT : ST_HDR;

  always_comb begin
    popOk    = 1'b0;
    fwd      = 1'b0;
    fwdFirst = 1'b0;
    fwdLast  = 1'b0;
    case (state)
      ST_HDR: begin
        // Environment loads wait for an idle pipe so they never overtake queued words.
        if (isEnv) begin
          popOk = !i_primBusy && !cmd.cmdValid;
        end else if (isPolyline || hdrLen != 4'd0) begin
          popOk    = slotFree;
          fwd      = 1'b1;
          fwdFirst = 1'b1;
          fwdLast  = hdrLen == 4'd1;
        end else begin
          popOk = 1'b1;
        end
      end
      ST_PARAM: begin
        popOk   = slotFree;
        fwd     = 1'b1;
        fwdLast = rem == 4'd1;
      end
      ST_POLYLINE: begin
        popOk   = slotFree;
        fwd     = 1'b1;
        fwdLast = isTerm && polyCnt >= (polyGouraud ? 2'd3 : 2'd2);
      end
      ST_XFER_IN: begin
        popOk = slotFree;
        fwd   = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_fifoRead = i_nrst && !i_fifoEmpty && popOk;

  gp0_out_slot u_slot (
    .i_clk (i_clk),
    .i_nrst(i_nrst),
    .load  (o_fifoRead && fwd),
    .data  (i_fifoData),
    .first (fwdFirst),
    .last  (fwdLast),
    .free  (slotFree),
    .cmd   (cmd)
  );

`ifdef GP0_TEXPAGE_FROM_POLY_EN
  logic [3:0] texRem;
`else
  assign o_loadTexPage = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state                  <= ST_HDR;
      afterState             <= ST_HDR;
      rem                    <= 4'd0;
      polyCnt                <= 2'd0;
      polyGouraud            <= 1'b0;
      o_loadE5Offsets        <= 1'b0;
      o_loadTexPageE1        <= 1'b0;
      o_loadTexWindowSetting <= 1'b0;
      o_loadDrawAreaTL       <= 1'b0;
      o_loadDrawAreaBR       <= 1'b0;
      o_loadMaskSetting      <= 1'b0;
      o_fifoDataOut          <= 32'd0;
`ifdef GP0_TEXPAGE_FROM_POLY_EN
      o_loadTexPage          <= 1'b0;
      texRem                 <= 4'd0;
`endif
    end else begin
      o_loadE5Offsets        <= 1'b0;
      o_loadTexPageE1        <= 1'b0;
      o_loadTexWindowSetting <= 1'b0;
      o_loadDrawAreaTL       <= 1'b0;
      o_loadDrawAreaBR       <= 1'b0;
      o_loadMaskSetting      <= 1'b0;
`ifdef GP0_TEXPAGE_FROM_POLY_EN
      o_loadTexPage          <= 1'b0;
`endif
      case (state)
        ST_HDR: if (o_fifoRead) begin
          if (isEnv) begin
            o_fifoDataOut <= i_fifoData;
            case (op)
              8'hE1:   o_loadTexPageE1        <= 1'b1;
              8'hE2:   o_loadTexWindowSetting <= 1'b1;
              8'hE3:   o_loadDrawAreaTL       <= 1'b1;
              8'hE4:   o_loadDrawAreaBR       <= 1'b1;
              8'hE5:   o_loadE5Offsets        <= 1'b1;
              default: o_loadMaskSetting      <= 1'b1;
            endcase
          end else if (isPolyline) begin
            state       <= ST_POLYLINE;
            polyCnt     <= 2'd0;
            polyGouraud <= op[4];
          end else if (hdrLen != 4'd0) begin
            rem        <= hdrLen - 4'd1;
            afterState <= hdrAfter;
            state      <= (hdrLen == 4'd1) ? hdrAfter : ST_PARAM;
`ifdef GP0_TEXPAGE_FROM_POLY_EN
            // UV1 is word 4 (5 when gouraud); expressed as the remaining count at that word.
            texRem <= (isPoly && op[2]) ? hdrLen - (op[4] ? 4'd5 : 4'd4) : 4'd0;
`endif
          end
        end
        ST_PARAM: if (o_fifoRead) begin
          rem <= rem - 4'd1;
          if (rem == 4'd1) state <= afterState;
`ifdef GP0_TEXPAGE_FROM_POLY_EN
          if (texRem != 4'd0 && rem == texRem) begin
            o_loadTexPage <= 1'b1;
            o_fifoDataOut <= i_fifoData;
          end
`endif
        end
        ST_POLYLINE: if (o_fifoRead) begin
          if (fwdLast) state <= ST_HDR;
          else if (polyCnt != 2'd3) polyCnt <= polyCnt + 2'd1;
        end
        ST_XFER_IN, ST_XFER_OUT: if (i_xferDone) state <= ST_HDR;
        default: state <= ST_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_gp0_command_sequencer.sv
// tb/tb_gp0_command_sequencer.sv - Randomized scoreboard bench for gp0_command_sequencer
// Honours GP0_TEXPAGE_FROM_POLY_EN for the texpage strobe expectation.
module tb_gp0_command_sequencer;

`ifdef GP0_TEXPAGE_FROM_POLY_EN
  localparam bit TEX_EN = 1'b1;
`else
  localparam bit TEX_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_nrst = 1'b0;
  logic        i_fifoEmpty;
  logic [31:0] i_fifoData;
  logic        o_fifoRead;
  logic        i_primBusy = 1'b0;
  logic        i_xferDone = 1'b0;
  logic        o_loadE5Offsets, o_loadTexPageE1, o_loadTexPage, o_loadTexWindowSetting;
  logic        o_loadDrawAreaTL, o_loadDrawAreaBR, o_loadMaskSetting;
  logic [31:0] o_fifoDataOut;

  gp0_command_sequencer_if cmd ();

  gp0_command_sequencer dut (
    .i_clk                 (i_clk),
    .i_nrst                (i_nrst),
    .i_fifoEmpty           (i_fifoEmpty),
    .i_fifoData            (i_fifoData),
    .o_fifoRead            (o_fifoRead),
    .i_primBusy            (i_primBusy),
    .i_xferDone            (i_xferDone),
    .o_loadE5Offsets       (o_loadE5Offsets),
    .o_loadTexPageE1       (o_loadTexPageE1),
    .o_loadTexPage         (o_loadTexPage),
    .o_loadTexWindowSetting(o_loadTexWindowSetting),
    .o_loadDrawAreaTL      (o_loadDrawAreaTL),
    .o_loadDrawAreaBR      (o_loadDrawAreaBR),
    .o_loadMaskSetting     (o_loadMaskSetting),
    .o_fifoDataOut         (o_fifoDataOut),
    .cmd                   (cmd)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {logic [31:0] w; logic hdr; logic xEnd; logic xOut;} fentry_t;
  typedef struct packed {logic [31:0] w; logic first; logic last;} fexp_t;
  typedef struct packed {logic [6:0] mask; logic [31:0] w;} sexp_t;

  fentry_t fifo[$];
  fexp_t   expFwd[$];
  sexp_t   expStb[$];
  int      nChecks = 0;
  int      nFails = 0;
  int      xoutWait = 0;
  bit      randReady = 1'b0, randBusy = 1'b0, busyForce = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic updHead();
    i_fifoEmpty = (fifo.size() == 0);
    if (fifo.size() != 0) i_fifoData = fifo[0].w;
    else i_fifoData = 32'h0;
  endtask

  task automatic pushWord(input logic [31:0] w, input logic hdr, input logic xEnd, input logic xOut);
    fentry_t e;
    e.w = w; e.hdr = hdr; e.xEnd = xEnd; e.xOut = xOut;
    fifo.push_back(e);
    updHead();
  endtask

  // Parameter words never carry the polyline terminator pattern by accident.
  function automatic logic [31:0] safe();
    logic [31:0] w;
    w = $urandom();
    if ((w & 32'hF000F000) == 32'h50005000) w[28] = ~w[28];
    return w;
  endfunction

  // Builds the command word by word from its field layout and records what must come out.
  task automatic pushCmd(input logic [31:0] h, input int k);
    logic [7:0]  op;
    logic [31:0] words[$];
    logic [31:0] w;
    int          texAt, nd, nv;
    logic        xout;
    fexp_t       f;
    sexp_t       s;
    op = h[31:24]; texAt = -1; nd = 0; xout = 1'b0;
    if (op >= 8'hE1 && op <= 8'hE6) begin
      pushWord(h, 1'b1, 1'b0, 1'b0);
      s.mask = 7'(1 << (op - 8'hE1)); s.w = h;
      expStb.push_back(s);
      return;
    end
    if (!(op == 8'h02 || (op >= 8'h20 && op <= 8'hDF))) begin
      pushWord(h, 1'b1, 1'b0, 1'b0);
      return;
    end
    words.push_back(h);
    case (op[7:5])
      3'd0: repeat (2) words.push_back(safe());
      3'd1: for (int v = 0; v < (op[3] ? 4 : 3); v++) begin
        if (op[4] && v > 0) words.push_back(safe());
        words.push_back(safe());
        if (op[2]) begin
          if (v == 1) texAt = words.size();
          words.push_back(safe());
        end
      end
      3'd2: begin
        nv = op[3] ? k : 2;
        for (int v = 0; v < nv; v++) begin
          if (op[4] && v > 0) words.push_back(safe());
          words.push_back(safe());
        end
        if (op[3]) words.push_back(($urandom() & 32'h0FFF0FFF) | 32'h50005000);
      end
      3'd3: begin
        words.push_back(safe());
        if (op[2]) words.push_back(safe());
        if (op[4:3] == 2'b00) words.push_back(safe());
      end
      3'd4: repeat (3) words.push_back(safe());
      3'd5: begin repeat (2) words.push_back(safe()); nd = k; end
      default: begin repeat (2) words.push_back(safe()); xout = 1'b1; end
    endcase
    foreach (words[i]) begin
      pushWord(words[i], i == 0, 1'b0, xout && i == words.size() - 1);
      f.w = words[i]; f.first = (i == 0); f.last = (i == words.size() - 1);
      expFwd.push_back(f);
    end
    for (int d = 0; d < nd; d++) begin
      w = $urandom();
      pushWord(w, 1'b0, d == nd - 1, 1'b0);
      f.w = w; f.first = 1'b0; f.last = 1'b0;
      expFwd.push_back(f);
    end
    if (TEX_EN && texAt >= 0) begin
      s.mask = 7'h40; s.w = words[texAt];
      expStb.push_back(s);
    end
  endtask

  function automatic logic [31:0] rndHdr();
    logic [7:0]  op;
    logic [31:0] r;
    int          sel;
    r = $urandom();
    sel = $urandom_range(0, 3);
    case ($urandom_range(0, 9))
      0: op = 8'hE1 + 8'($urandom_range(0, 5));
      1: op = (sel == 0) ? 8'($urandom_range(0, 1)) : (sel == 1) ? 8'($urandom_range(3, 31)) :
              (sel == 2) ? 8'hE0 : 8'($urandom_range(231, 255));
      2: op = 8'h02;
      3: op = {3'b001, r[28:24]};
      4: op = {3'b010, r[28], 1'b0, r[26:24]};
      5: op = {3'b010, r[28], 1'b1, r[26:24]};
      6: op = {3'b011, r[28:24]};
      7: op = {3'b100, r[28:24]};
      8: op = {3'b101, r[28:24]};
      default: op = {3'b110, r[28:24]};
    endcase
    return {op, r[23:0]};
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    @(negedge i_clk);
    while ((fifo.size() != 0 || expFwd.size() != 0 || expStb.size() != 0 || cmd.cmdValid || xoutWait != 0)
           && n < 20000) begin
      @(negedge i_clk);
      n++;
    end
    check(name, 64'(n >= 20000), 64'd0);
  endtask

  task automatic checkResetOutputs(input string name);
    check({name, "_ctl"}, {o_fifoRead, o_loadE5Offsets, o_loadTexPageE1, o_loadTexPage, o_loadTexWindowSetting,
                           o_loadDrawAreaTL, o_loadDrawAreaBR, o_loadMaskSetting,
                           cmd.cmdValid, cmd.cmdFirst, cmd.cmdLast}, 64'd0);
    check({name, "_data"}, {cmd.cmdData, o_fifoDataOut}, 64'd0);
  endtask

  // Driver: FIFO model, ready/busy randomization and transfer-done pulses.
  initial begin : driver
    fentry_t e;
    logic    willPop;
    cmd.cmdReady = 1'b1;
    updHead();
    forever begin
      @(negedge i_clk);
      cmd.cmdReady = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_primBusy   = busyForce ? 1'b1 : randBusy ? ($urandom_range(0, 3) == 0) : 1'b0;
      i_xferDone   = 1'b0;
      if (xoutWait > 0) begin
        xoutWait--;
        if (xoutWait == 0) i_xferDone = 1'b1;
      end
      #1;
      willPop = o_fifoRead;
      if (willPop && fifo[0].xEnd) i_xferDone = 1'b1;
      if (fifo.size() != 0 && fifo[0].hdr && fifo[0].w[31:24] >= 8'hE1 && fifo[0].w[31:24] <= 8'hE6)
        check("envHold", 64'(o_fifoRead && (i_primBusy || cmd.cmdValid || !i_nrst)), 64'd0);
      @(posedge i_clk);
      #1;
      if (willPop) begin
        e = fifo.pop_front();
        if (e.xOut) xoutWait = $urandom_range(1, 5);
        updHead();
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a word or a strobe.
  initial begin : monitor
    fexp_t      f;
    sexp_t      s;
    logic [6:0] stb;
    forever begin
      @(negedge i_clk);
      #2;
      if (!i_nrst) continue;
      if (cmd.cmdValid && cmd.cmdReady) begin
        if (expFwd.size() == 0) check("fwdExtra", {cmd.cmdData, cmd.cmdFirst, cmd.cmdLast}, 64'd0);
        else begin
          f = expFwd.pop_front();
          check("fwdWord", {cmd.cmdData, cmd.cmdFirst, cmd.cmdLast}, {f.w, f.first, f.last});
        end
      end
      stb = {o_loadTexPage, o_loadMaskSetting, o_loadE5Offsets, o_loadDrawAreaBR,
             o_loadDrawAreaTL, o_loadTexWindowSetting, o_loadTexPageE1};
      if (stb != 7'd0) begin
        if (expStb.size() == 0) check("stbExtra", {stb, o_fifoDataOut}, 64'd0);
        else begin
          s = expStb.pop_front();
          check("strobe", {stb, o_fifoDataOut}, {s.mask, s.w});
        end
      end
    end
  end

  initial begin : main
    repeat (3) @(negedge i_clk);
    #2;
    checkResetOutputs("reset");
    @(negedge i_clk);
    i_nrst = 1'b1;

    pushCmd(32'hE5000801, 0);
    drain("drainE5");
    pushCmd(32'h2C808080, 0);
    drain("drainPoly");
    pushCmd(32'h48FFFFFF, 3);
    drain("drainPolyline");

    busyForce = 1'b1;
    @(negedge i_clk);
    pushCmd(32'hE1000200, 0);
    repeat (10) @(negedge i_clk);
    check("e1Held", 64'(fifo.size()), 64'd1);
    busyForce = 1'b0;
    drain("drainE1");

    pushCmd(32'hA0000000, 6);
    pushCmd(32'hE3001234, 0);
    drain("drainXferIn");

    randReady = 1'b1;
    randBusy  = 1'b1;
    for (int i = 0; i < 300; i++) pushCmd(rndHdr(), $urandom_range(2, 5));
    drain("drainRandom");

    randReady = 1'b0;
    randBusy  = 1'b0;
    pushWord(32'h64112233, 1'b1, 1'b0, 1'b0);
    pushWord(32'h00400040, 1'b0, 1'b0, 1'b0);
    expFwd.push_back({32'h64112233, 1'b1, 1'b0});
    expFwd.push_back({32'h00400040, 1'b0, 1'b0});
    drain("drainRectPart");
    i_nrst = 1'b0;
    pushCmd(32'hE5000801, 0);
    @(negedge i_clk);
    #2;
    checkResetOutputs("midReset");
    check("noPopInReset", 64'(fifo.size()), 64'd1);
    @(negedge i_clk);
    i_nrst = 1'b1;
    pushCmd(32'h02AABBCC, 0);
    drain("drainAfterReset");

    check("leftFwd", 64'(expFwd.size()), 64'd0);
    check("leftStb", 64'(expStb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
